counter_bg_updown: RTL and testbench

//  - WIDTH-bit up/down counter that steps through either the natural binary sequence or the reflected Gray sequence, selected at run time by mode.
//  - Parametrised successor of the team's 3-bit binary/Gray JK counter. Adds width, direction, enable, parallel load, terminal count and a binary readback.
//  - Sits in the sequencer/address-generation path. Gray mode feeds clock-domain-crossing pointers; binary mode feeds local indexing.

---
 rtl/counter_bg_pkg.sv | 22 ++
 rtl/jk_async_res.sv | 16 +
 rtl/counter_bg_updown.sv | 55 +++++
 tb/tb_counter_bg_updown.sv | 111 +++++++++++
 4 files changed

// File: rtl/counter_bg_pkg.sv
// counter_bg_pkg: shared constants and binary/Gray conversion helpers for counter_bg_updown
//   MODE_BIN / MODE_GRAY : values of the mode input
//   DIR_DOWN / DIR_UP    : values of the dir input
//   bin2gray / gray2bin  : conversions on a MAX_W-bit vector; narrower codes are
//                          zero-extended on the way in and truncated on the way out
package counter_bg_pkg;
   localparam int MAX_W = 16;
   localparam logic MODE_BIN  = 1'b0;
   localparam logic MODE_GRAY = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_UP    = 1'b1;
   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction
   // Zero upper bits stay zero through the prefix XOR, so the narrow result is exact.
   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] b;
      b[MAX_W-1] = g[MAX_W-1];
      for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
endpackage

// File: rtl/jk_async_res.sv
// jk_async_res: JK flip-flop with asynchronous active-high reset to 0
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   j,k : set / clear inputs (both high toggles)
//   q   : flip-flop state
module jk_async_res (
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= 1'b0;
      else     q <= (j & ~q) | (~k & q);
endmodule

// File: rtl/counter_bg_updown.sv
// counter_bg_updown: WIDTH-bit up/down counter stepping in binary or Gray order, built on JK flip-flops
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset, clears count
//   en       : advance one step
//   mode     : 0 binary sequence, 1 Gray sequence
//   dir      : 1 up, 0 down
//   load     : load load_val as a raw code (overrides en)
//   load_val : value to load
//   count    : current code held in the JK array
//   code_bin : binary index of count under the current mode
//   tc       : terminal count, high on the enabled step that wraps (or saturates)
// Build option: define COUNTER_BG_SAT_EN to saturate at the terminal index instead of wrapping.
module counter_bg_updown
   import counter_bg_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] code_bin,
   output logic             tc
);
   localparam logic [WIDTH-1:0] TOP = '1;
   logic [WIDTH-1:0] nidx, step, nxt, j, k;
   logic             at_end;
   // The held code is reinterpreted under whatever mode is current; it is never re-encoded.
   assign code_bin = (mode == MODE_GRAY) ? WIDTH'(gray2bin(MAX_W'(count))) : count;
   assign at_end   = (dir == DIR_UP) ? (code_bin == TOP) : (code_bin == '0);
   assign tc       = en & ~load & at_end;
   assign nidx     = (dir == DIR_UP) ? code_bin + WIDTH'(1) : code_bin - WIDTH'(1);
   assign step     = (mode == MODE_GRAY) ? WIDTH'(bin2gray(MAX_W'(nidx))) : nidx;
`ifdef COUNTER_BG_SAT_EN
   assign nxt = load ? load_val : (en & ~at_end) ? step : count;
`else
   assign nxt = load ? load_val : en ? step : count;
`endif
   // Drive each JK pair so the flop lands on nxt: set when rising, clear when falling.
   assign j = nxt & ~count;
   assign k = ~nxt & count;
   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      jk_async_res u_jk (
         .clk (clk),
         .rst (reset),
         .j   (j[g]),
         .k   (k[g]),
         .q   (count[g])
      );
   end
endmodule

// File: tb/tb_counter_bg_updown.sv
// tb_counter_bg_updown: directed and randomized checks of counter_bg_updown against an index-level model
module tb_counter_bg_updown;
   localparam int W = 3;
   localparam int N = 1 << W;
   logic         clk = 1'b0;
   logic         reset, en, mode, dir, load;
   logic [W-1:0] load_val, count, code_bin;
   logic         tc;
   int           checks = 0;
   int           errors = 0;
   int           mcount = 0;
   counter_bg_updown #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .mode     (mode),
      .dir      (dir),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .code_bin (code_bin),
      .tc       (tc)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic int gray(input int n);
      return n ^ (n >> 1);
   endfunction
   // Index of a code: itself in binary, otherwise its position in the Gray sequence.
   function automatic int index_of(input int c, input bit m);
      if (!m) return c;
      for (int n = 0; n < N; n++) if (gray(n) == c) return n;
      return -1;
   endfunction
   function automatic bit at_terminal(input int c, input bit m, input bit d);
      return d ? index_of(c, m) == N - 1 : index_of(c, m) == 0;
   endfunction
   task automatic cyc(input bit e, input bit m, input bit d, input bit l, input int lv);
      int i, ni;
      logic [W-1:0] prev;
      en = e; mode = m; dir = d; load = l; load_val = W'(lv);
      #1;
      check("count", count, mcount);
      check("code_bin", code_bin, index_of(mcount, m));
      check("tc", tc, e && !l && at_terminal(mcount, m, d));
      prev = count;
      @(posedge clk);
      if (l) mcount = lv % N;
      else if (e) begin
         i  = index_of(mcount, m);
         ni = d ? (i + 1) % N : (i + N - 1) % N;
`ifdef COUNTER_BG_SAT_EN
         if (at_terminal(mcount, m, d)) ni = i;
`endif
         mcount = m ? gray(ni) : ni;
      end
      #1;
      if (m && e && !l && count != prev) check("gray_one_bit", $countones(count ^ prev), 1);
      @(negedge clk);
   endtask
   task automatic async_reset();
      en = 1'b0; dir = 1'b1;
      #2 reset = 1'b1;
      #1;
      mcount = 0;
      check("rst_count", count, 0);
      check("rst_code_bin", code_bin, 0);
      check("rst_tc", tc, 0);
      @(posedge clk);
      #1 check("rst_hold", count, 0);
      @(negedge clk);
      reset = 1'b0;
   endtask
   initial begin
      reset = 1'b1; en = 0; mode = 0; dir = 1; load = 0; load_val = '0;
      #2;
      check("reset_async", count, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (9) cyc(1, 0, 1, 0, 0);
      cyc(0, 1, 1, 1, 0);
      repeat (8) cyc(1, 1, 1, 0, 0);
      repeat (2) cyc(1, 1, 0, 0, 0);
      repeat (2) cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 1, 1, 6);
      cyc(1, 1, 1, 0, 0);
      cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 1, 1, 5);
      async_reset();
      repeat (2) cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 1, 0, 0);
      cyc(0, 0, 1, 1, N - 1);
      repeat (3) cyc(1, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0);
      repeat (3) cyc(1, 1, 0, 0, 0);
      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 39) == 0) async_reset();
         else cyc($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, N - 1)));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
